// File: rtl/dfd_tn_pkg.sv
// Shared state, pointer and width definitions for the trace-sink write controller.
// `DFD_TRC_SINK_PARITY_EN widens every SRAM row by one even-parity bit.
package dfd_tn_pkg;
  localparam int TRC_RAM_INSTANCES       = 2;
  localparam int TRC_RAM_INDEX_WIDTH_DEF = 9;
  localparam int TRC_PTR_W_DEF           = TRC_RAM_INDEX_WIDTH_DEF + $clog2(TRC_RAM_INSTANCES);
`ifdef DFD_TRC_SINK_PARITY_EN
  localparam int TRC_PARITY_W = 1;
`else
  localparam int TRC_PARITY_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    STOPPED = 2'd2
  } TrcSinkState_e;

  typedef logic [TRC_PTR_W_DEF-1:0] TrcSinkPtr_t;
endpackage

// File: rtl/dfd_trace_sink_rd_arb.sv
// Read-back arbiter: grants a read when no write hits the same bank; data is valid 2 cycles after grant.
// A blocked read simply waits (requester holds i_rd_req); read data is held between reads.
module dfd_trace_sink_rd_arb #(
  parameter int N_BANK = 2,
  parameter int BANK_W = 1,
  parameter int MEM_W  = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_vld,
  input  logic [BANK_W-1:0]       wr_bank,
  input  logic                    rd_req,
  input  logic [BANK_W-1:0]       rd_bank,
  input  logic [N_BANK*MEM_W-1:0] mem_rdata,
  output logic                    rd_gnt,
  output logic                    rd_vld,
  output logic [MEM_W-1:0]        rd_word
);
  logic              p1_vld_q, p1_vld_d;
  logic [BANK_W-1:0] p1_bank_q, p1_bank_d;
  logic              rd_vld_q, rd_vld_d;
  logic [MEM_W-1:0]  rd_word_q, rd_word_d;

  // The write always wins a same-bank collision.
  assign rd_gnt = rd_req & ~(wr_vld & (wr_bank == rd_bank));

  always_comb begin
    p1_vld_d  = rd_gnt;
    p1_bank_d = rd_gnt ? rd_bank : p1_bank_q;
    rd_vld_d  = p1_vld_q;
    rd_word_d = rd_word_q;
    if (p1_vld_q) begin
      rd_word_d = mem_rdata[p1_bank_q*MEM_W +: MEM_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_vld_q  <= 1'b0;
      p1_bank_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_word_q <= '0;
    end else begin
      p1_vld_q  <= p1_vld_d;
      p1_bank_q <= p1_bank_d;
      rd_vld_q  <= rd_vld_d;
      rd_word_q <= rd_word_d;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_word = rd_word_q;
endmodule

// File: rtl/dfd_trace_sink_wr_ctrl.sv
// Trace-sink write controller: beats striped round-robin into N_BANK SRAMs, written 1 cycle after accept.
// o_trc_rdy only in ACTIVE and not during i_clr; `DFD_TRC_SINK_PARITY_EN adds o_rd_perr.
module dfd_trace_sink_wr_ctrl
  import dfd_tn_pkg::*;
#(
  parameter  int TRC_RAM_INDEX_WIDTH = 9,
  parameter  int DATA_W              = 64,
  parameter  int N_BANK              = TRC_RAM_INSTANCES,
  localparam int BANK_LOG            = $clog2(N_BANK),
  localparam int BANK_W              = (BANK_LOG > 0) ? BANK_LOG : 1,
  localparam int PTR_W               = TRC_RAM_INDEX_WIDTH + BANK_LOG,
  localparam int MEM_W               = DATA_W + TRC_PARITY_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_trc_enable,
  input  logic                              i_stop_on_wrap,
  input  logic                              i_clr,
  input  logic                              i_trc_vld,
  input  logic [DATA_W-1:0]                 i_trc_data,
  output logic                              o_trc_rdy,
  input  logic                              i_rd_req,
  input  logic [PTR_W-1:0]                  i_rd_addr,
  output logic                              o_rd_gnt,
  output logic                              o_rd_vld,
  output logic [DATA_W-1:0]                 o_rd_data,
`ifdef DFD_TRC_SINK_PARITY_EN
  output logic                              o_rd_perr,
`endif
  output logic [PTR_W-1:0]                  o_wr_ptr,
  output logic                              o_wrapped,
  output logic                              o_stopped,
  output logic [N_BANK-1:0]                 o_mem_ce,
  output logic [N_BANK-1:0]                 o_mem_we,
  output logic [N_BANK*TRC_RAM_INDEX_WIDTH-1:0] o_mem_addr,
  output logic [N_BANK*MEM_W-1:0]           o_mem_wdata,
  input  logic [N_BANK*MEM_W-1:0]           i_mem_rdata
);
  localparam logic [PTR_W-1:0] PTR_MAX = {PTR_W{1'b1}};

  typedef struct packed {
    logic                           ce;
    logic                           we;
    logic [TRC_RAM_INDEX_WIDTH-1:0] addr;
    logic [MEM_W-1:0]               wdata;
  } SinkMemPktOut_s;

  typedef struct packed {
    logic [MEM_W-1:0] rdata;
  } SinkMemPktIn_s;

  function automatic logic [BANK_W-1:0] bank_of(input logic [PTR_W-1:0] p);
    return BANK_W'(p & PTR_W'(N_BANK - 1));
  endfunction

  function automatic logic [TRC_RAM_INDEX_WIDTH-1:0] row_of(input logic [PTR_W-1:0] p);
    return TRC_RAM_INDEX_WIDTH'(p >> BANK_LOG);
  endfunction

  TrcSinkState_e                  state_q, state_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic                           wrapped_q, wrapped_d;
  logic                           wr_vld_q, wr_vld_d;
  logic [BANK_W-1:0]              wr_bank_q, wr_bank_d;
  logic [TRC_RAM_INDEX_WIDTH-1:0] wr_row_q, wr_row_d;
  logic [MEM_W-1:0]               wr_word_q, wr_word_d;

  logic                           accept;
  logic [MEM_W-1:0]               beat_word;
  logic [BANK_W-1:0]              rd_bank;
  logic [TRC_RAM_INDEX_WIDTH-1:0] rd_row;
  logic [MEM_W-1:0]               rd_word;
  SinkMemPktIn_s  [N_BANK-1:0]    mem_in;
  SinkMemPktOut_s [N_BANK-1:0]    mem_out;

`ifdef DFD_TRC_SINK_PARITY_EN
  assign beat_word = {^i_trc_data, i_trc_data};
  assign o_rd_perr = ^rd_word;
`else
  assign beat_word = i_trc_data;
`endif

  assign o_trc_rdy = (state_q == ACTIVE) & ~i_clr;
  assign accept    = i_trc_vld & o_trc_rdy;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wrapped_d = wrapped_q;
    wr_vld_d  = accept;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    wr_word_d = wr_word_q;
    if (accept) begin
      wr_bank_d = bank_of(ptr_q);
      wr_row_d  = row_of(ptr_q);
      wr_word_d = beat_word;
      ptr_d     = ptr_q + 1'b1;
      if (ptr_q == PTR_MAX) wrapped_d = 1'b1;
    end
    unique case (state_q)
      IDLE:    if (i_trc_enable) state_d = ACTIVE;
      ACTIVE: begin
        if (!i_trc_enable)                                   state_d = IDLE;
        else if (accept && ptr_q == PTR_MAX && i_stop_on_wrap) state_d = STOPPED;
      end
      STOPPED: if (!i_trc_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clear overrides everything, including a beat offered in the same cycle.
    if (i_clr) begin
      ptr_d     = '0;
      wrapped_d = 1'b0;
      state_d   = i_trc_enable ? ACTIVE : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wrapped_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_bank_q <= '0;
      wr_row_q  <= '0;
      wr_word_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wrapped_q <= wrapped_d;
      wr_vld_q  <= wr_vld_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      wr_word_q <= wr_word_d;
    end
  end

  assign o_wr_ptr  = ptr_q;
  assign o_wrapped = wrapped_q;
  assign o_stopped = (state_q == STOPPED);

  assign rd_bank = bank_of(i_rd_addr);
  assign rd_row  = row_of(i_rd_addr);
  assign mem_in  = i_mem_rdata;

  dfd_trace_sink_rd_arb #(
    .N_BANK (N_BANK),
    .BANK_W (BANK_W),
    .MEM_W  (MEM_W)
  ) u_rd_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_vld    (wr_vld_q),
    .wr_bank   (wr_bank_q),
    .rd_req    (i_rd_req),
    .rd_bank   (rd_bank),
    .mem_rdata (mem_in),
    .rd_gnt    (o_rd_gnt),
    .rd_vld    (o_rd_vld),
    .rd_word   (rd_word)
  );

  assign o_rd_data = rd_word[DATA_W-1:0];

  always_comb begin
    mem_out = '0;
    for (int b = 0; b < N_BANK; b++) begin
      if (wr_vld_q && (wr_bank_q == BANK_W'(b))) begin
        mem_out[b].ce    = 1'b1;
        mem_out[b].we    = 1'b1;
        mem_out[b].addr  = wr_row_q;
        mem_out[b].wdata = wr_word_q;
      end else if (o_rd_gnt && (rd_bank == BANK_W'(b))) begin
        mem_out[b].ce   = 1'b1;
        mem_out[b].addr = rd_row;
      end
    end
  end

  for (genvar g = 0; g < N_BANK; g++) begin : g_bank
    assign o_mem_ce[g]                                             = mem_out[g].ce;
    assign o_mem_we[g]                                             = mem_out[g].we;
    assign o_mem_addr[g*TRC_RAM_INDEX_WIDTH +: TRC_RAM_INDEX_WIDTH] = mem_out[g].addr;
    assign o_mem_wdata[g*MEM_W +: MEM_W]                           = mem_out[g].wdata;
  end
endmodule

// File: tb/tb_dfd_trace_sink_wr_ctrl.sv
// Bench for dfd_trace_sink_wr_ctrl with 2 banks x 4 rows; honours `DFD_TRC_SINK_PARITY_EN.
module tb_dfd_trace_sink_wr_ctrl;
  localparam int IDX    = 2;
  localparam int NB     = 2;
  localparam int PTR_W  = 3;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
`ifdef DFD_TRC_SINK_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 i_trc_enable = 1'b0, i_stop_on_wrap = 1'b0, i_clr = 1'b0;
  logic                 i_trc_vld = 1'b0;
  logic [DATA_W-1:0]    i_trc_data = '0;
  logic                 o_trc_rdy;
  logic                 i_rd_req = 1'b0;
  logic [PTR_W-1:0]     i_rd_addr = '0;
  logic                 o_rd_gnt, o_rd_vld;
  logic [DATA_W-1:0]    o_rd_data;
  logic [PTR_W-1:0]     o_wr_ptr;
  logic                 o_wrapped, o_stopped;
  logic [NB-1:0]        o_mem_ce, o_mem_we;
  logic [NB*IDX-1:0]    o_mem_addr;
  logic [NB*MEM_W-1:0]  o_mem_wdata;
  logic [NB*MEM_W-1:0]  i_mem_rdata;
`ifdef DFD_TRC_SINK_PARITY_EN
  logic                 o_rd_perr;
`endif

  always #5 clk = ~clk;

  dfd_trace_sink_wr_ctrl #(.TRC_RAM_INDEX_WIDTH(IDX), .DATA_W(DATA_W), .N_BANK(NB)) dut (
    .clk(clk), .reset_n(reset_n), .i_trc_enable(i_trc_enable), .i_stop_on_wrap(i_stop_on_wrap),
    .i_clr(i_clr), .i_trc_vld(i_trc_vld), .i_trc_data(i_trc_data), .o_trc_rdy(o_trc_rdy),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_gnt(o_rd_gnt), .o_rd_vld(o_rd_vld),
    .o_rd_data(o_rd_data),
`ifdef DFD_TRC_SINK_PARITY_EN
    .o_rd_perr(o_rd_perr),
`endif
    .o_wr_ptr(o_wr_ptr), .o_wrapped(o_wrapped), .o_stopped(o_stopped),
    .o_mem_ce(o_mem_ce), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  // SRAM bank model, 1-cycle read latency; flip_en corrupts bit 5 when reading linear addr 1.
  logic [MEM_W-1:0] sram   [NB][1<<IDX];
  logic [MEM_W-1:0] sram_q [NB];
  bit               flip_en = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        sram_q[b] <= '0;
        for (int r = 0; r < (1<<IDX); r++) sram[b][r] <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (o_mem_ce[b]) begin
          if (o_mem_we[b]) sram[b][o_mem_addr[b*IDX +: IDX]] <= o_mem_wdata[b*MEM_W +: MEM_W];
          else sram_q[b] <= sram[b][o_mem_addr[b*IDX +: IDX]] ^
                            ((flip_en && b == 1 && o_mem_addr[b*IDX +: IDX] == 0) ? MEM_W'(32) : '0);
        end
      end
    end
  end
  assign i_mem_rdata = {sram_q[1], sram_q[0]};

  int checks = 0, failures = 0;

  // Reference model: circular buffer of linear addresses plus capture status.
  logic [DATA_W-1:0] m_buf [DEPTH];
  int  m_ptr = 0;
  bit  m_wrapped = 0, m_stopped = 0, m_active = 0;
  bit  obs_rdy, exp_rdy;

  task automatic tick(input bit vld, input logic [DATA_W-1:0] dat);
    bit acc;
    @(negedge clk);
    i_trc_vld  = vld;
    i_trc_data = dat;
    #1;
    obs_rdy = o_trc_rdy;
    exp_rdy = m_active && !i_clr;
    acc     = exp_rdy && vld;
    @(posedge clk);
    if (i_clr) begin
      m_ptr = 0; m_wrapped = 0; m_stopped = 0; m_active = i_trc_enable;
    end else begin
      if (acc) begin
        m_buf[m_ptr] = dat;
        if (m_ptr == DEPTH-1) begin
          m_wrapped = 1;
          if (i_stop_on_wrap && i_trc_enable) m_stopped = 1;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (!i_trc_enable) m_stopped = 0;
      m_active = i_trc_enable && !m_stopped;
    end
    #1;
    i_trc_vld = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [DATA_W-1:0] dat, output int lat, output bit perr);
    int k;
    lat = -1; dat = '0; perr = 1'b0; k = 0;
    i_rd_req  = 1'b1;
    i_rd_addr = PTR_W'(addr);
    #1;
    while (!o_rd_gnt && k < 10) begin @(posedge clk); #1; k++; end
    if (!o_rd_gnt) begin i_rd_req = 1'b0; return; end
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    k = 1;
    while (!o_rd_vld && k < 10) begin @(posedge clk); #1; k++; end
    if (o_rd_vld) begin
      lat = k;
      dat = o_rd_data;
`ifdef DFD_TRC_SINK_PARITY_EN
      perr = o_rd_perr;
`endif
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < DEPTH; a++) m_buf[a] = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_trc_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%0b exp=0", o_trc_rdy); end
    checks++; if (o_wr_ptr !== '0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", o_wr_ptr); end
    checks++; if ({o_wrapped, o_stopped, o_rd_vld} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {o_wrapped, o_stopped, o_rd_vld}); end
    checks++; if ({o_mem_ce, o_mem_we} !== '0) begin failures++; $display("FAIL reset_mem got=%b exp=0", {o_mem_ce, o_mem_we}); end
    checks++; if (o_rd_data !== '0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", o_rd_data); end
    reset_n = 1'b1;
    tick(0, '0);
    checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL idle_rdy got=%0b exp=0", obs_rdy); end
  endtask

  task automatic test_basic();
    i_trc_enable = 1'b1; i_stop_on_wrap = 1'b0;
    tick(1, 64'hDEAD);
    checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL basic_idle_rdy got=%0b exp=%0b", obs_rdy, exp_rdy); end
    for (int i = 0; i < 5; i++) begin
      tick(1, 64'hA0 + 64'(i));
      checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL basic_rdy beat=%0d got=%0b exp=%0b", i, obs_rdy, exp_rdy); end
      if (i == 0) begin
        checks++; if ({o_mem_ce, o_mem_we} !== 4'b0101) begin failures++; $display("FAIL basic_wr_strobe got=%b exp=0101", {o_mem_ce, o_mem_we}); end
        checks++; if (o_mem_addr[IDX-1:0] !== '0) begin failures++; $display("FAIL basic_wr_row got=%0d exp=0", o_mem_addr[IDX-1:0]); end
        checks++; if (o_mem_wdata[DATA_W-1:0] !== 64'hA0) begin failures++; $display("FAIL basic_wr_data got=%0h exp=a0", o_mem_wdata[DATA_W-1:0]); end
      end
    end
    tick(0, '0);
    checks++; if (o_wr_ptr !== PTR_W'(m_ptr)) begin failures++; $display("FAIL basic_ptr got=%0d exp=%0d", o_wr_ptr, m_ptr); end
    for (int a = 0; a < 5; a++) begin
      checks++; if (sram[a%NB][a/NB][DATA_W-1:0] !== m_buf[a]) begin failures++; $display("FAIL basic_mem addr=%0d got=%0h exp=%0h", a, sram[a%NB][a/NB][DATA_W-1:0], m_buf[a]); end
    end
  endtask

  task automatic test_stop_wrap();
    i_stop_on_wrap = 1'b1;
    i_clr = 1'b1; tick(0, '0); i_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1, {$urandom, $urandom});
      checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL stop_rdy beat=%0d got=%0b exp=%0b", i, obs_rdy, exp_rdy); end
    end
    checks++; if ({o_stopped, o_wrapped} !== {m_stopped, m_wrapped}) begin failures++; $display("FAIL stop_flags got=%b exp=%b", {o_stopped, o_wrapped}, {m_stopped, m_wrapped}); end
    tick(1, 64'h9999);
    checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL stop_9th_rdy got=%0b exp=%0b", obs_rdy, exp_rdy); end
    tick(0, '0);
    checks++; if (o_wr_ptr !== PTR_W'(m_ptr)) begin failures++; $display("FAIL stop_ptr got=%0d exp=%0d", o_wr_ptr, m_ptr); end
    for (int a = 0; a < DEPTH; a++) begin
      checks++; if (sram[a%NB][a/NB][DATA_W-1:0] !== m_buf[a]) begin failures++; $display("FAIL stop_mem addr=%0d got=%0h exp=%0h", a, sram[a%NB][a/NB][DATA_W-1:0], m_buf[a]); end
    end
    i_trc_enable = 1'b0; tick(0, '0);
    checks++; if (o_stopped !== m_stopped) begin failures++; $display("FAIL stop_release got=%0b exp=%0b", o_stopped, m_stopped); end
    i_trc_enable = 1'b1; tick(0, '0);
  endtask

  task automatic test_overwrite();
    i_stop_on_wrap = 1'b0;
    i_clr = 1'b1; tick(0, '0); i_clr = 1'b0;
    for (int i = 0; i < 10; i++) tick(1, 64'hB000 + 64'(i));
    tick(0, '0);
    checks++; if ({o_wrapped, o_stopped} !== {m_wrapped, m_stopped}) begin failures++; $display("FAIL ovw_flags got=%b exp=%b", {o_wrapped, o_stopped}, {m_wrapped, m_stopped}); end
    checks++; if (o_wr_ptr !== PTR_W'(m_ptr)) begin failures++; $display("FAIL ovw_ptr got=%0d exp=%0d", o_wr_ptr, m_ptr); end
    for (int a = 0; a < DEPTH; a++) begin
      checks++; if (sram[a%NB][a/NB][DATA_W-1:0] !== m_buf[a]) begin failures++; $display("FAIL ovw_mem addr=%0d got=%0h exp=%0h", a, sram[a%NB][a/NB][DATA_W-1:0], m_buf[a]); end
    end
  endtask

  task automatic test_clr();
    tick(1, 64'hC2);
    checks++; if (o_wr_ptr !== PTR_W'(m_ptr)) begin failures++; $display("FAIL clr_pre_ptr got=%0d exp=%0d", o_wr_ptr, m_ptr); end
    i_clr = 1'b1; tick(1, 64'h55); i_clr = 1'b0;
    checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL clr_rdy got=%0b exp=%0b", obs_rdy, exp_rdy); end
    checks++; if (o_mem_we !== '0) begin failures++; $display("FAIL clr_no_write got=%b exp=00", o_mem_we); end
    checks++; if ({o_wr_ptr, o_wrapped} !== {PTR_W'(m_ptr), m_wrapped}) begin failures++; $display("FAIL clr_state got=%b exp=%b", {o_wr_ptr, o_wrapped}, {PTR_W'(m_ptr), m_wrapped}); end
  endtask

  task automatic test_rd_conflict();
    for (int i = 0; i < 4; i++) tick(1, 64'hD0 + 64'(i));
    tick(1, 64'hD4);
    i_rd_req = 1'b1; i_rd_addr = 3'd2;
    #1;
    checks++; if ({o_rd_gnt, o_mem_we} !== 3'b001) begin failures++; $display("FAIL conf_blocked got=%b exp=001", {o_rd_gnt, o_mem_we}); end
    @(posedge clk); #1;
    checks++; if ({o_rd_gnt, o_mem_ce, o_mem_we} !== 5'b10100) begin failures++; $display("FAIL conf_gnt got=%b exp=10100", {o_rd_gnt, o_mem_ce, o_mem_we}); end
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    checks++; if (o_rd_vld !== 1'b0) begin failures++; $display("FAIL conf_early_vld got=%0b exp=0", o_rd_vld); end
    @(posedge clk); #1;
    checks++; if ({o_rd_vld, o_rd_data} !== {1'b1, m_buf[2]}) begin failures++; $display("FAIL conf_data vld=%0b got=%0h exp=%0h", o_rd_vld, o_rd_data, m_buf[2]); end
    @(posedge clk); #1;
    checks++; if ({o_rd_vld, o_rd_data} !== {1'b0, m_buf[2]}) begin failures++; $display("FAIL conf_hold vld=%0b got=%0h exp=%0h", o_rd_vld, o_rd_data, m_buf[2]); end
    tick(1, 64'hD5);
    i_rd_req = 1'b1; i_rd_addr = 3'd0;
    #1;
    checks++; if ({o_rd_gnt, o_mem_ce, o_mem_we} !== 5'b11110) begin failures++; $display("FAIL par_gnt got=%b exp=11110", {o_rd_gnt, o_mem_ce, o_mem_we}); end
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    @(posedge clk); #1;
    checks++; if ({o_rd_vld, o_rd_data} !== {1'b1, m_buf[0]}) begin failures++; $display("FAIL par_data vld=%0b got=%0h exp=%0h", o_rd_vld, o_rd_data, m_buf[0]); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    int lat;
    bit pe;
    for (int c = 0; c < 240; c++) begin
      if (c % 40 == 0) i_stop_on_wrap = 1'($urandom_range(0, 1));
      i_trc_enable = ($urandom_range(0, 9) != 0);
      i_clr        = ($urandom_range(0, 29) == 0);
      tick(1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
      i_clr = 1'b0;
      checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_rdy cyc=%0d got=%0b exp=%0b", c, obs_rdy, exp_rdy); end
      checks++; if (o_wr_ptr !== PTR_W'(m_ptr)) begin failures++; $display("FAIL rnd_ptr cyc=%0d got=%0d exp=%0d", c, o_wr_ptr, m_ptr); end
      checks++; if ({o_wrapped, o_stopped} !== {m_wrapped, m_stopped}) begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", c, {o_wrapped, o_stopped}, {m_wrapped, m_stopped}); end
    end
    i_trc_enable = 1'b0;
    tick(0, '0); tick(0, '0);
    for (int a = 0; a < DEPTH; a++) begin
      rd(a, d, lat, pe);
      checks++; if (lat !== 2) begin failures++; $display("FAIL rnd_rd_lat addr=%0d got=%0d exp=2", a, lat); end
      checks++; if (d !== m_buf[a]) begin failures++; $display("FAIL rnd_rd_data addr=%0d got=%0h exp=%0h", a, d, m_buf[a]); end
    end
  endtask

`ifdef DFD_TRC_SINK_PARITY_EN
  task automatic test_parity();
    logic [DATA_W-1:0] d;
    int lat;
    bit pe;
    flip_en = 1'b1;
    rd(1, d, lat, pe);
    checks++; if ({lat == 2, pe} !== 2'b11) begin failures++; $display("FAIL perr_flip lat=%0d got=%0b exp=1", lat, pe); end
    rd(0, d, lat, pe);
    checks++; if ({lat == 2, pe} !== 2'b10) begin failures++; $display("FAIL perr_clean lat=%0d got=%0b exp=0", lat, pe); end
    flip_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stop_wrap();
    test_overwrite();
    test_clr();
    test_rd_conflict();
    test_random();
`ifdef DFD_TRC_SINK_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
